// File: rtl/router_port_rx.sv
// router_port_rx: receive side of one router input port.
// Recovers a serially sent destination address and LSB-first payload bytes
// from the frame_n/valid_n/din protocol and queues the bytes in a small FIFO
// that drains through a valid/ready stream with a last flag.
// Optional build macro ROUTER_RX_STATS_EN adds saturating good-packet and
// error counters on ports pkt_cnt/err_cnt.
module router_port_rx #(
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              din,
  output logic              busy_n,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              pkt_err
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int AIDX_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PAD_W  = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  localparam logic [AIDX_W-1:0] AIDX_LAST = AIDX_W'(ADDR_W - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);
  localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(PAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_BUSY  = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PAD, S_DATA, S_DROP} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr_sh, w_addr_next, r_addr;
  logic [AIDX_W-1:0]   r_aidx;
  logic [PAD_W-1:0]    r_pad_cnt;
  logic [DATA_W-1:0]   r_byte, w_byte_next;
  logic [BIDX_W-1:0]   r_bidx;
  logic                r_addr_vld, r_pkt_err, r_busy_n;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_last_mem;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_next;
  logic w_full, w_pop, w_push, w_err, w_byte_done, w_addr_done, w_pad_done;

  assign w_full       = (r_count == CNT_FULL);
  assign m_valid      = (r_count != '0);
  assign w_pop        = m_valid & m_ready;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign m_data       = r_mem[r_rd_ptr];
  assign m_last       = r_last_mem[r_rd_ptr];
  assign addr         = r_addr;
  assign addr_vld     = r_addr_vld;
  assign pkt_err      = r_pkt_err;
  assign busy_n       = r_busy_n;

  // Shift registers with the current serial bit dropped into its slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_addr_next         = r_addr_sh;
    w_addr_next[r_aidx] = din;
    w_byte_next         = r_byte;
    w_byte_next[r_bidx] = din;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: if (!frame_n) w_state_next = S_ADDR;
      S_ADDR: begin
        if (w_err)            w_state_next = S_IDLE;
        else if (w_addr_done) w_state_next = S_PAD;
      end
      S_PAD: begin
        if (w_err)           w_state_next = frame_n ? S_IDLE : S_DROP;
        else if (w_pad_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_err)                       w_state_next = frame_n ? S_IDLE : S_DROP;
        else if (w_byte_done && frame_n) w_state_next = S_IDLE;
      end
      S_DROP: if (frame_n) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-state control strobes: address/pad completion, byte push and errors.
  always_comb begin
    w_addr_done = 1'b0;
    w_pad_done  = 1'b0;
    w_byte_done = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      S_ADDR: begin
        w_err       = frame_n;
        w_addr_done = !frame_n && (r_aidx == AIDX_LAST);
      end
      S_PAD: begin
        w_err      = frame_n || !valid_n;
        w_pad_done = !w_err && (r_pad_cnt == PAD_LAST);
      end
      S_DATA: begin
        w_byte_done = !valid_n && (r_bidx == BIDX_LAST);
        // A completed byte that finds the FIFO full with no pop is an overflow.
        w_err = (frame_n && (valid_n || r_bidx != BIDX_LAST)) ||
                (w_byte_done && w_full && !w_pop);
      end
      default: ;
    endcase
    w_push = w_byte_done && !w_err;
  end

  // Address capture, pad and bit counters, and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr_sh  <= '0;
      r_aidx     <= '0;
      r_pad_cnt  <= '0;
      r_byte     <= '0;
      r_bidx     <= '0;
      r_addr     <= '0;
      r_addr_vld <= 1'b0;
      r_pkt_err  <= 1'b0;
    end else begin
      r_addr_vld <= w_addr_done;
      r_pkt_err  <= w_err;
      if (w_addr_done) r_addr <= w_addr_next;
      unique case (r_state)
        S_IDLE: begin
          r_pad_cnt <= '0;
          r_bidx    <= '0;
          if (!frame_n) begin
            r_addr_sh <= ADDR_W'(din);
            r_aidx    <= AIDX_W'(1);
          end
        end
        S_ADDR: if (!frame_n) begin
          r_addr_sh <= w_addr_next;
          r_aidx    <= r_aidx + AIDX_W'(1);
        end
        S_PAD:  r_pad_cnt <= r_pad_cnt + PAD_W'(1);
        S_DATA: begin
          // Completed or aborted byte restarts at bit 0; a partial byte is simply forgotten.
          if (w_err || w_byte_done) r_bidx <= '0;
          else if (!valid_n) begin
            r_byte <= w_byte_next;
            r_bidx <= r_bidx + BIDX_W'(1);
          end
        end
        S_DROP: begin
          r_pad_cnt <= '0;
          r_bidx    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Output byte FIFO with registered almost-full back-pressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: storage is reset because m_data/m_last are read straight from it and must be 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_last_mem <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy_n   <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr]      <= w_byte_next;
        r_last_mem[r_wr_ptr] <= frame_n;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count  <= w_count_next;
      r_busy_n <= (w_count_next < CNT_BUSY);
    end
  end

`ifdef ROUTER_RX_STATS_EN
  logic [15:0] r_pkt_cnt, r_err_cnt;
  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;

  // Saturating counters of delivered packets and aborted packets.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push && frame_n && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_err && r_err_cnt != 16'hFFFF)             r_err_cnt <= r_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: directed table of packets, hand-written
// abort/overflow/reset sequences, and randomized traffic checked against a
// packet-level model (bytes in order, last on final byte, busy from occupancy).
module tb_router_port_rx;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n, frame_n, valid_n, din, m_ready;
  logic       busy_n, addr_vld, m_last, m_valid, pkt_err;
  logic [3:0] addr;
  logic [7:0] m_data;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt, err_cnt;
`endif

  router_port_rx dut (
    .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
    .busy_n(busy_n), .addr(addr), .addr_vld(addr_vld), .m_data(m_data),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .pkt_err(pkt_err)
`ifdef ROUTER_RX_STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed traffic, owned by the monitor only.
  logic [8:0] got_q[$];
  logic [3:0] got_addr[$];
  int         popped = 0;
  int         err_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_data});
        popped++;
      end
      if (addr_vld) got_addr.push_back(addr);
      if (pkt_err) err_seen++;
    end
  end

  // Model state.
  logic [8:0] exp_q[$];
  logic [3:0] exp_addr[$];
  int got_idx = 0, addr_idx = 0, popped_base = 0, sent = 0, good_pkts = 0, err_base = 0;
  int n_checks = 0, n_fail = 0;
  bit rnd_done;

  typedef struct {
    logic [3:0]  addr;
    int          n;
    logic [47:0] data;
    int          pct;
    bit          ready;
    int          exp_err;
    int          exp_bytes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  function automatic int occ();
    return sent - (popped - popped_base);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic d);
    frame_n = f; valid_n = v; din = d;
    tick();
  endtask

  task automatic send_header(input logic [3:0] a);
    exp_addr.push_back(a);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i]);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit honour, input int pct);
    for (int i = 0; i < 8; i++) begin
      int guard;
      guard = 0;
      forever begin
        bit hold;
        if (honour)
          check("busy_n", 32'(busy_n), (occ() >= FIFO_DEPTH - 1) ? 32'd0 : 32'd1);
        hold = (honour && !busy_n) || (int'($urandom_range(0, 99)) < pct);
        if (!hold) break;
        if (guard > 500) begin
          timeout_fail("sender_stall");
          break;
        end
        guard++;
        drive(1'b0, 1'b1, 1'b0);
      end
      drive(last && i == 7, 1'b0, b[i]);
    end
    sent++;
  endtask

  task automatic send_packet(input logic [3:0] a, input logic [47:0] data, input int n,
                             input bit honour, input int pct);
    send_header(a);
    for (int k = 0; k < n; k++) begin
      send_byte(data[k*8 +: 8], k == n - 1, honour, pct);
      exp_q.push_back({k == n - 1, data[k*8 +: 8]});
    end
    good_pkts++;
  endtask

  task automatic drain();
    int g;
    g = 0;
    m_ready = 1'b1;
    frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
    while (m_valid && g < 200) begin
      tick();
      g++;
    end
    if (m_valid) timeout_fail("drain");
    tick();
    sent = popped - popped_base;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_byte_count"}, 32'(got_q.size() - got_idx), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (got_idx + i < got_q.size())
        check({tag, "_byte"}, 32'(got_q[got_idx + i]), 32'(exp_q[i]));
    check({tag, "_addr_count"}, 32'(got_addr.size() - addr_idx), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      if (addr_idx + i < got_addr.size())
        check({tag, "_addr"}, 32'(got_addr[addr_idx + i]), 32'(exp_addr[i]));
    got_idx  = got_q.size();
    addr_idx = got_addr.size();
    exp_q.delete();
    exp_addr.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy_n"},   32'(busy_n),   32'd1);
    check({tag, "_addr"},     32'(addr),     32'd0);
    check({tag, "_addr_vld"}, 32'(addr_vld), 32'd0);
    check({tag, "_m_valid"},  32'(m_valid),  32'd0);
    check({tag, "_m_last"},   32'(m_last),   32'd0);
    check({tag, "_m_data"},   32'(m_data),   32'd0);
    check({tag, "_pkt_err"},  32'(pkt_err),  32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int e0;
    vecs[0] = '{addr: 4'hA, n: 2, data: 48'h0000_0000_A53C, pct: 0,  ready: 1'b1, exp_err: 0, exp_bytes: 2};
    vecs[1] = '{addr: 4'hA, n: 2, data: 48'h0000_0000_A53C, pct: 40, ready: 1'b1, exp_err: 0, exp_bytes: 2};
    vecs[2] = '{addr: 4'h5, n: 1, data: 48'h0000_0000_00FF, pct: 0,  ready: 1'b1, exp_err: 0, exp_bytes: 1};
    vecs[3] = '{addr: 4'h0, n: 6, data: 48'h0504_0302_0100, pct: 0,  ready: 1'b0, exp_err: 0, exp_bytes: 6};
    vecs[4] = '{addr: 4'hF, n: 4, data: 48'h0000_C0DE_7E81, pct: 20, ready: 1'b1, exp_err: 0, exp_bytes: 4};

    reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // Directed packet table.
    for (int t = 0; t < 5; t++) begin
      e0 = err_seen;
      m_ready = vecs[t].ready;
      fork
        send_packet(vecs[t].addr, vecs[t].data, vecs[t].n, 1'b1, vecs[t].pct);
        begin
          if (!vecs[t].ready) begin
            repeat (60) tick();
            m_ready = 1'b1;
          end
        end
      join
      check("vec_bytes", 32'(exp_q.size()), 32'(vecs[t].exp_bytes));
      drain();
      check("vec_err", 32'(err_seen - e0), 32'(vecs[t].exp_err));
      compare_stream("vec");
    end

    // Sender ignores busy_n: overflow on the 5th byte, then DROP until frame_n rises.
    e0 = err_seen;
    m_ready = 1'b0;
    send_header(4'h7);
    for (int k = 0; k < 5; k++) send_byte(8'(8'h10 + k), 1'b0, 1'b0, 0);
    check("overflow_pkt_err", 32'(pkt_err), 32'd1);
    check("overflow_busy_n", 32'(busy_n), 32'd0);
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("overflow_err_count", 32'(err_seen - e0), 32'd1);
    check("overflow_head", 32'({m_last, m_data}), 32'h010);
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 8'(8'h10 + k)});
    drain();
    compare_stream("overflow");

    // frame_n rises after 5 bits of byte 2, then a new frame starts the very next cycle.
    e0 = err_seen;
    m_ready = 1'b1;
    send_header(4'h9);
    send_byte(8'h5A, 1'b0, 1'b1, 0);
    exp_q.push_back({1'b0, 8'h5A});
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    check("abort_pkt_err", 32'(pkt_err), 32'd1);
    send_packet(4'h3, 48'h77, 1, 1'b1, 0);
    tick();
    check("abort_err_count", 32'(err_seen - e0), 32'd1);
    drain();
    compare_stream("abort");

    // One-cycle reset in the middle of the payload.
    m_ready = 1'b0;
    send_header(4'h6);
    send_byte(8'h81, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    check_reset_values("midreset");
    reset_n = 1'b1;
    got_idx = got_q.size(); addr_idx = got_addr.size();
    popped_base = popped; sent = 0; good_pkts = 0; err_base = err_seen;
    exp_q.delete(); exp_addr.delete();
    drive(1'b1, 1'b1, 1'b0);
    check("midreset_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    send_packet(4'hC, 48'h3CC3, 2, 1'b1, 0);
    drain();
    check("midreset_err_count", 32'(err_seen - err_base), 32'd0);
    compare_stream("midreset");

    // Randomized back-to-back traffic with random downstream readiness.
    e0 = err_seen;
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 25; p++) begin
          logic [63:0] r;
          r = {$urandom(), $urandom()};
          send_packet(4'($urandom), r[47:0], int'($urandom_range(1, 6)), 1'b1,
                      int'($urandom_range(0, 30)));
          repeat ($urandom_range(0, 2)) drive(1'b1, 1'b1, 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();
    check("random_err_count", 32'(err_seen - e0), 32'd0);
    compare_stream("random");

`ifdef ROUTER_RX_STATS_EN
    check("stats_pkt_cnt", 32'(pkt_cnt), 32'(good_pkts));
    check("stats_err_cnt", 32'(err_cnt), 32'(err_seen - err_base));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
